// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus: req/ack handshake between a load/store master and the
// data RAM responder.
interface data_mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ack_o, rdata_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ack_o, rdata_o, busy_o, err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a req/ack handshake with WAIT_CY wait states.
// Optional feature: define MISALIGN_CHECK_EN to reject accesses with addr[1:0] != 0.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int WAIT_CY = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_mem_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    // The transaction entering RESP this edge comes straight from the bus when
    // there are no wait states, otherwise from the latched request.
    logic          enter_resp;
    logic          we_sel;
    logic [31:0]   addr_sel;
    logic [IW-1:0] idx_q, idx_sel;
    logic          oor_q, oor_sel;
    logic          mis_q, mis_sel;
    logic          err_q, err_sel;

    assign we_sel   = (state_q == ST_IDLE) ? bus.we_i   : we_q;
    assign addr_sel = (state_q == ST_IDLE) ? bus.addr_i : addr_q;
    assign idx_q    = addr_q[IW+1:2];
    assign idx_sel  = addr_sel[IW+1:2];
    assign oor_q    = |addr_q[31:IW+2];
    assign oor_sel  = |addr_sel[31:IW+2];

`ifdef MISALIGN_CHECK_EN
    assign mis_q    = |addr_q[1:0];
    assign mis_sel  = |addr_sel[1:0];
`else
    logic unused_addr_lsb;
    assign mis_q    = 1'b0;
    assign mis_sel  = 1'b0;
    assign unused_addr_lsb = ^addr_sel[1:0];
`endif

    assign err_q   = oor_q | mis_q;
    assign err_sel = oor_sel | mis_sel;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_d      = mem_q;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
                    cnt_d   = 4'(WAIT_CY);
                    if (WAIT_CY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (we_q && !err_q) begin
                    mem_d[idx_q] = wdata_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data is registered on the edge entering RESP so it is stable
        // for the whole ack cycle; writes leave it untouched.
        if (enter_resp) begin
            if (mis_sel) begin
                rdata_d = '0;
            end else if (!we_sel) begin
                rdata_d = oor_sel ? '0 : mem_q[idx_sel];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            // NOTE: the RAM must read as zero after reset, so it is built from resettable flops.
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.ack_o   = (state_q == ST_RESP);
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.err_o   = (state_q == ST_RESP) && err_q;
    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random traffic
// compared against a word-array reference model.
module tb_data_mem_responder;
    localparam int DEPTH = 128;
    localparam int WCY   = 2;

    logic clk;
    logic rst_n;

    data_mem_responder_if m ();
    data_mem_responder_if m0 ();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CY(WCY)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (m)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CY(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (m0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr);
        logic e;
        e = (addr >= 32'(DEPTH * 4));
`ifdef MISALIGN_CHECK_EN
        if (addr % 4 != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_rdata = '0;
    endtask

    // Apply one access to the model at the moment of its ack; returns expectations.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic exp_err, output logic [31:0] exp_rdata);
        exp_err = model_err(addr);
        if (we) begin
            if (!exp_err) ref_mem[model_idx(addr)] = wdata;
`ifdef MISALIGN_CHECK_EN
            if (addr % 4 != 0) ref_rdata = '0;
`endif
        end else begin
            ref_rdata = exp_err ? 32'h0 : ref_mem[model_idx(addr)];
        end
        exp_rdata = ref_rdata;
    endtask

    // Single-cycle req pulse; checks busy/ack timing, err and rdata on the main DUT.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rd;
        @(negedge clk);
        m.req_i   = 1'b1;
        m.we_i    = we;
        m.addr_i  = addr;
        m.wdata_i = wdata;
        @(posedge clk);
        #1;
        m.req_i   = 1'b0;
        m.we_i    = ~we;
        m.addr_i  = $urandom;
        m.wdata_i = $urandom;
        for (int k = 1; k <= WCY; k++) begin
            @(negedge clk);
            check({tag, " wait ack"}, 32'(m.ack_o), 32'd0);
            check({tag, " wait busy"}, 32'(m.busy_o), 32'd1);
        end
        @(negedge clk);
        model_apply(we, addr, wdata, exp_err, exp_rd);
        check({tag, " ack"}, 32'(m.ack_o), 32'd1);
        check({tag, " busy at ack"}, 32'(m.busy_o), 32'd1);
        check({tag, " err"}, 32'(m.err_o), 32'(exp_err));
        check({tag, " rdata"}, m.rdata_o, exp_rd);
        @(negedge clk);
        check({tag, " ack pulse"}, 32'(m.ack_o), 32'd0);
        check({tag, " idle busy"}, 32'(m.busy_o), 32'd0);
        check({tag, " idle err"}, 32'(m.err_o), 32'd0);
        check({tag, " rdata held"}, m.rdata_o, exp_rd);
    endtask

    initial begin
        int acks;
        logic        rw;
        logic [31:0] ra;
        m.req_i  = 0; m.we_i  = 0; m.addr_i  = '0; m.wdata_i  = '0;
        m0.req_i = 0; m0.we_i = 0; m0.addr_i = '0; m0.wdata_i = '0;
        rst_n = 1'b0;
        model_reset();
        #23;
        check("reset ack", 32'(m.ack_o), 32'd0);
        check("reset busy", 32'(m.busy_o), 32'd0);
        check("reset err", 32'(m.err_o), 32'd0);
        check("reset rdata", m.rdata_o, 32'd0);
        check("reset ack0", 32'(m0.ack_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_access("wr 10", 1'b1, 32'h10, 32'hDEADBEEF);
        do_access("rd 10", 1'b0, 32'h10, 32'h0);
        check("rd 10 value", m.rdata_o, 32'hDEADBEEF);

        do_access("rd 200 oor", 1'b0, 32'h200, 32'h0);
        do_access("wr 1fc", 1'b1, 32'h1FC, 32'hFFFFFFFF);
        do_access("rd 1fc", 1'b0, 32'h1FC, 32'h0);
        check("rd 1fc value", m.rdata_o, 32'hFFFFFFFF);
        do_access("wr 200 oor", 1'b1, 32'h200, 32'h12345678);
        do_access("rd 0 after oor wr", 1'b0, 32'h0, 32'h0);

        // Request during WAIT must be ignored.
        @(negedge clk);
        m.req_i = 1'b1; m.we_i = 1'b1; m.addr_i = 32'h20; m.wdata_i = 32'h11;
        @(posedge clk);
        #1 m.req_i = 1'b0;
        @(negedge clk);
        m.req_i = 1'b1; m.we_i = 1'b1; m.addr_i = 32'h24; m.wdata_i = 32'h22;
        @(posedge clk);
        #1 m.req_i = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m.ack_o) acks++;
        end
        check("ignored req ack count", 32'(acks), 32'd1);
        ref_mem[model_idx(32'h20)] = 32'h11;
        do_access("rd 24", 1'b0, 32'h24, 32'h0);
        check("rd 24 value", m.rdata_o, 32'h0);
        do_access("rd 20", 1'b0, 32'h20, 32'h0);
        check("rd 20 value", m.rdata_o, 32'h11);

        // Reset during WAIT drops the write.
        @(negedge clk);
        m.req_i = 1'b1; m.we_i = 1'b1; m.addr_i = 32'h08; m.wdata_i = 32'h55;
        @(posedge clk);
        #1 m.req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset ack", 32'(m.ack_o), 32'd0);
        check("mid reset busy", 32'(m.busy_o), 32'd0);
        check("mid reset rdata", m.rdata_o, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_access("rd 08 after reset", 1'b0, 32'h08, 32'h0);
        check("rd 08 value", m.rdata_o, 32'h0);
        do_access("rd 10 after reset", 1'b0, 32'h10, 32'h0);

        // Misaligned write: error or word-containing write depending on build.
        do_access("wr 13", 1'b1, 32'h13, 32'hA5);
        do_access("rd 10 after wr 13", 1'b0, 32'h10, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = 32'($urandom_range(0, DEPTH * 4 - 1));
            do_access(rw ? "rand wr" : "rand rd", rw, ra, $urandom);
        end

        // Zero-wait-state instance with req held high: ack every other cycle.
        @(negedge clk);
        m0.req_i = 1'b1; m0.we_i = 1'b0; m0.addr_i = 32'h0;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("wcy0 ack cycle %0d", k), 32'(m0.ack_o), 32'(k % 2));
            check($sformatf("wcy0 err cycle %0d", k), 32'(m0.err_o), 32'd0);
        end
        m0.req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wcy0 idle ack", 32'(m0.ack_o), 32'd0);
        check("wcy0 idle busy", 32'(m0.busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
